intra16_recon: RTL



---
 rtl/intra16_recon.sv | 280 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/intra16_recon.sv
// intra16_recon: rebuilds a 16x16 luma block from an i16 prediction mode,
// quantized DC/AC levels and dequant steps (VP8-style reconstruction).
module intra16_recon #(
  parameter int BLOCK_SIZE = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic [9:0]                            x,
  input  logic [9:0]                            y,
  input  logic [1:0]                            mode_i16,
  input  logic [7:0]                            top_left,
  input  logic [8*BLOCK_SIZE-1:0]               top,
  input  logic [8*BLOCK_SIZE-1:0]               left,
  input  logic [255:0]                          dc_levels,
  input  logic [4095:0]                         ac_levels,
  input  logic [15:0]                           iq_dc,
  input  logic [15:0]                           iq_ac,
  output logic [8*BLOCK_SIZE*BLOCK_SIZE-1:0]    Yout,
  output logic                                  busy,
  output logic                                  done
);

  typedef enum logic [2:0] {
    S_IDLE, S_PRED, S_WHT0, S_WHT1, S_DEQ, S_ROW, S_COL, S_DONE
  } state_t;

  state_t      state, state_n;
  logic [3:0]  blk, blk_n;
  logic        busy_n, done_n;

  // Operands captured on the accepted start
  logic [1:0]     mode_q;
  logic [9:0]     x_q, y_q;
  logic [7:0]     tl_q;
  logic [127:0]   top_q, left_q;
  logic [255:0]   dcl_q;
  logic [4095:0]  acl_q;
  logic [15:0]    iqdc_q, iqac_q;

  logic [2047:0]  yout_q;
  logic [2047:0]  pred_img;

  logic signed [31:0] win    [16];
  logic signed [31:0] wht0_n [16];
  logic signed [31:0] wht1_n [16];
  logic signed [31:0] wtmp   [16];
  logic signed [31:0] wdc    [16];
  logic signed [31:0] deq_n  [16];
  logic signed [31:0] coef   [16];
  logic signed [31:0] row_n  [16];
  logic signed [31:0] ctmp   [16];
  logic [7:0]         col_pix[16];

  logic [31:0] rb, cb, bi;
  assign rb = {28'd0, blk[3:2], 2'b00};
  assign cb = {28'd0, blk[1:0], 2'b00};
  assign bi = {28'd0, blk};

  assign Yout = yout_q;

  function automatic logic [7:0] clip8(input logic signed [31:0] v);
    if (v < 0)        return 8'd0;
    else if (v > 255) return 8'd255;
    else              return v[7:0];
  endfunction

  function automatic logic signed [31:0] dequant(input logic [15:0] lv, input logic [15:0] st);
    logic signed [31:0] l, s;
    l = {{16{lv[15]}}, lv};
    s = {16'd0, st};
    return l * s;
  endfunction

  function automatic logic signed [31:0] mul1(input logic signed [31:0] a);
    logic signed [63:0] ax, p;
    ax = {{32{a[31]}}, a};
    p  = ax * 64'sd85627;
    return 32'(p >>> 16);
  endfunction

  function automatic logic signed [31:0] mul2(input logic signed [31:0] a);
    logic signed [63:0] ax, p;
    ax = {{32{a[31]}}, a};
    p  = ax * 64'sd35468;
    return 32'(p >>> 16);
  endfunction

  // State, block counter and registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      blk   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      blk   <= blk_n;
      busy  <= busy_n;
      done  <= done_n;
    end
  end

  // Next-state sequencing: prediction, two WHT passes, then DEQ/ROW/COL per block
  always_comb begin
    state_n = state;
    blk_n   = blk;
    busy_n  = busy;
    done_n  = 1'b0;
    case (state)
      S_IDLE: if (start) begin
        state_n = S_PRED;
        busy_n  = 1'b1;
      end
      S_PRED: state_n = S_WHT0;
      S_WHT0: state_n = S_WHT1;
      S_WHT1: begin
        state_n = S_DEQ;
        blk_n   = '0;
      end
      S_DEQ:  state_n = S_ROW;
      S_ROW:  state_n = S_COL;
      S_COL: begin
        if (blk == 4'd15) begin
          state_n = S_DONE;
          done_n  = 1'b1;
        end else begin
          state_n = S_DEQ;
          blk_n   = blk + 4'd1;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
        busy_n  = 1'b0;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // 16x16 prediction image from the latched neighbours
  logic [12:0]        sum_top, sum_left;
  logic [7:0]         dc_pred, px;
  logic signed [31:0] tm;
  always_comb begin
    sum_top  = '0;
    sum_left = '0;
    dc_pred  = '0;
    px       = '0;
    tm       = '0;
    pred_img = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      sum_top  = sum_top  + {5'd0, top_q[8*i +: 8]};
      sum_left = sum_left + {5'd0, left_q[8*i +: 8]};
    end
    if (x_q == '0 && y_q == '0)  dc_pred = 8'd128;
    else if (y_q == '0)          dc_pred = 8'((sum_left + 13'd8) >> 4);
    else if (x_q == '0)          dc_pred = 8'((sum_top + 13'd8) >> 4);
    else                         dc_pred = 8'((sum_top + sum_left + 13'd16) >> 5);
    for (int unsigned r = 0; r < 16; r++) begin
      for (int unsigned c = 0; c < 16; c++) begin
        tm = $signed({24'd0, left_q[8*r +: 8]}) + $signed({24'd0, top_q[8*c +: 8]})
           - $signed({24'd0, tl_q});
        case (mode_q)
          2'd0:    px = dc_pred;
          2'd1:    px = clip8(tm);
          2'd2:    px = top_q[8*c +: 8];
          default: px = left_q[8*r +: 8];
        endcase
        pred_img[8*(16*r+c) +: 8] = px;
      end
    end
  end

  // Inverse WHT of the dequantized DC levels: vertical pass then horizontal pass
  logic signed [31:0] wa0, wa1, wa2, wa3, wdcv;
  always_comb begin
    wa0 = '0; wa1 = '0; wa2 = '0; wa3 = '0; wdcv = '0;
    win    = '{default: '0};
    wht0_n = '{default: '0};
    wht1_n = '{default: '0};
    for (int unsigned k = 0; k < 16; k++)
      win[k] = dequant(dcl_q[16*k +: 16], iqdc_q);
    for (int unsigned i = 0; i < 4; i++) begin
      wa0 = win[i] + win[12+i];
      wa1 = win[4+i] + win[8+i];
      wa2 = win[4+i] - win[8+i];
      wa3 = win[i] - win[12+i];
      wht0_n[i]    = wa0 + wa1;
      wht0_n[4+i]  = wa3 + wa2;
      wht0_n[8+i]  = wa0 - wa1;
      wht0_n[12+i] = wa3 - wa2;
    end
    for (int unsigned i = 0; i < 4; i++) begin
      wdcv = wtmp[4*i] + 32'sd3;
      wa0  = wdcv + wtmp[4*i+3];
      wa1  = wtmp[4*i+1] + wtmp[4*i+2];
      wa2  = wtmp[4*i+1] - wtmp[4*i+2];
      wa3  = wdcv - wtmp[4*i+3];
      wht1_n[4*i]   = (wa0 + wa1) >>> 3;
      wht1_n[4*i+1] = (wa3 + wa2) >>> 3;
      wht1_n[4*i+2] = (wa0 - wa1) >>> 3;
      wht1_n[4*i+3] = (wa3 - wa2) >>> 3;
    end
  end

  // Per-block dequant and 4x4 inverse DCT; the first pass works down columns
  // into ctmp, the second produces output rows, adds prediction and clips
  logic signed [31:0] da, db, dcc, dd, ddc, dsum;
  logic [7:0]         pb;
  always_comb begin
    da = '0; db = '0; dcc = '0; dd = '0; ddc = '0; dsum = '0; pb = '0;
    deq_n   = '{default: '0};
    row_n   = '{default: '0};
    col_pix = '{default: '0};
    deq_n[0] = wdc[blk];
    for (int unsigned k = 1; k < 16; k++)
      deq_n[k] = dequant(acl_q[256*bi + 16*k +: 16], iqac_q);
    for (int unsigned i = 0; i < 4; i++) begin
      da  = coef[i] + coef[8+i];
      db  = coef[i] - coef[8+i];
      dcc = mul2(coef[4+i]) - mul1(coef[12+i]);
      dd  = mul1(coef[4+i]) + mul2(coef[12+i]);
      row_n[4*i]   = da + dd;
      row_n[4*i+1] = db + dcc;
      row_n[4*i+2] = db - dcc;
      row_n[4*i+3] = da - dd;
    end
    for (int unsigned i = 0; i < 4; i++) begin
      ddc = ctmp[i] + 32'sd4;
      da  = ddc + ctmp[8+i];
      db  = ddc - ctmp[8+i];
      dcc = mul2(ctmp[4+i]) - mul1(ctmp[12+i]);
      dd  = mul1(ctmp[4+i]) + mul2(ctmp[12+i]);
      for (int unsigned j = 0; j < 4; j++) begin
        case (j)
          0:       dsum = (da + dd) >>> 3;
          1:       dsum = (db + dcc) >>> 3;
          2:       dsum = (db - dcc) >>> 3;
          default: dsum = (da - dd) >>> 3;
        endcase
        pb = yout_q[8*(16*(rb+i) + cb + j) +: 8];
        col_pix[4*i+j] = clip8($signed({24'd0, pb}) + dsum);
      end
    end
  end

  // Operand capture and datapath registers, one stage per state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= '0; x_q <= '0; y_q <= '0; tl_q <= '0;
      top_q <= '0; left_q <= '0; dcl_q <= '0; acl_q <= '0;
      iqdc_q <= '0; iqac_q <= '0;
      yout_q <= '0;
      wtmp <= '{default: '0};
      wdc  <= '{default: '0};
      coef <= '{default: '0};
      ctmp <= '{default: '0};
    end else begin
      case (state)
        S_IDLE: if (start) begin
          mode_q <= mode_i16; x_q <= x; y_q <= y; tl_q <= top_left;
          top_q <= top; left_q <= left; dcl_q <= dc_levels; acl_q <= ac_levels;
          iqdc_q <= iq_dc; iqac_q <= iq_ac;
        end
        S_PRED: yout_q <= pred_img;
        S_WHT0: wtmp <= wht0_n;
        S_WHT1: wdc  <= wht1_n;
        S_DEQ:  coef <= deq_n;
        S_ROW:  ctmp <= row_n;
        S_COL: begin
          for (int unsigned i = 0; i < 4; i++)
            for (int unsigned j = 0; j < 4; j++)
              yout_q[8*(16*(rb+i) + cb + j) +: 8] <= col_pix[4*i+j];
        end
        default: ;
      endcase
    end
  end

endmodule
